// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the Hamming SECDED engine:
// status/state encodings and codeword geometry functions.
package hamming_pkg;

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_CORR   = 2'b01,
    ST_UNCORR = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SCAN = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic is_pow2(input int v);
    return (v > 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
  endfunction

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int par_w_f(input int data_w);
    int p;
    p = 32'sd1;
    while ((32'sd1 << p) < (data_w + p + 32'sd1)) p = p + 32'sd1;
    return p;
  endfunction

  // Codeword position of data bit idx: the idx-th non-power-of-two position >= 3.
  function automatic int data_pos_f(input int idx);
    int pos;
    int cnt;
    pos = 32'sd2;
    cnt = 32'sd0;
    while (cnt <= idx) begin
      pos = pos + 32'sd1;
      if (!is_pow2(pos)) cnt = cnt + 32'sd1;
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_seq_if.sv
// Request/response bundle between the core and the SECDED engine;
// master = issuing core, slave = engine.
interface hamming_secded_seq_if import hamming_pkg::*; #(
  parameter  int DATA_W = 11,
  localparam int PAR_W  = par_w_f(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
);
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CODE_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_status;
  logic [PAR_W-1:0]  out_syndrome;

  modport master (
    output in_valid, in_mode, in_word, out_ready,
    input  in_ready, out_valid, out_code, out_data, out_status, out_syndrome
  );

  modport slave (
    input  in_valid, in_mode, in_word, out_ready,
    output in_ready, out_valid, out_code, out_data, out_status, out_syndrome
  );
endinterface

// File: rtl/hamming_scatter_gather.sv
// Combinational data <-> codeword mapping: scatter places data bits on the
// non-power-of-two positions (parity slots and bit 0 zero); gather reverses it.
module hamming_scatter_gather import hamming_pkg::*; #(
  parameter  int DATA_W = 11,
  localparam int PAR_W  = par_w_f(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic [DATA_W-1:0] scat_data,
  output logic [CODE_W-1:0] scat_code,
  input  logic [CODE_W-1:0] gath_code,
  output logic [DATA_W-1:0] gath_data
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_map
    localparam int POS = data_pos_f(i);
    assign scat_code[POS] = scat_data[i];
    assign gath_data[i]   = gath_code[POS];
  end

  for (genvar p = 0; p < CODE_W; p++) begin : g_slot
    if ((p == 0) || is_pow2(p)) begin : g_zero
      assign scat_code[p] = 1'b0;
    end
  end

endmodule

// File: rtl/hamming_secded_seq.sv
// Multi-cycle Hamming SECDED encoder/decoder, one codeword position per cycle.
// Define HAMMING_ERR_CNT_EN to add the corrected/uncorrectable event counters.
module hamming_secded_seq import hamming_pkg::*; #(
  parameter  int DATA_W = 11,
  localparam int PAR_W  = par_w_f(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef HAMMING_ERR_CNT_EN
  input  logic        cnt_clr,
  output logic [15:0] corr_cnt,
  output logic [15:0] uncorr_cnt,
`endif
  hamming_secded_seq_if.slave bus
);

  state_e            state_r;
  state_e            state_nx_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              mode_r;
  logic [CODE_W-1:0] work_r;
  logic [PAR_W-1:0]  idx_r;
  logic [PAR_W-1:0]  syn_r;
  logic              par_r;
  logic [CODE_W-1:0] out_code_r;
  logic [DATA_W-1:0] out_data_r;
  status_e           out_status_r;
  logic [PAR_W-1:0]  out_syndrome_r;

  logic              accept_s;
  logic              scan_last_s;
  logic              q_s;
  logic [CODE_W-1:0] fix_word_s;
  status_e           fix_status_s;
  logic [CODE_W-1:0] scat_code_s;
  logic [DATA_W-1:0] gath_data_s;

  assign accept_s    = bus.in_valid & in_ready_r;
  assign scan_last_s = (idx_r == PAR_W'(CODE_W - 1));

  hamming_scatter_gather #(.DATA_W(DATA_W)) u_sg (
    .scat_data (bus.in_word[DATA_W-1:0]),
    .scat_code (scat_code_s),
    .gath_code (fix_word_s),
    .gath_data (gath_data_s)
  );

  // State register plus the handshake flags derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == S_IDLE);
      out_valid_r <= (state_nx_s == S_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE:  if (accept_s)      state_nx_s = S_SCAN; else state_nx_s = S_IDLE;
      S_SCAN:  if (scan_last_s)   state_nx_s = S_FIX;  else state_nx_s = S_SCAN;
      S_FIX:                      state_nx_s = S_DONE;
      S_DONE:  if (bus.out_ready) state_nx_s = S_IDLE; else state_nx_s = S_DONE;
      default:                    state_nx_s = S_IDLE;
    endcase
  end

  // FIX-cycle result: encode fills parity slots; decode classifies and corrects.
  always_comb begin
    fix_word_s   = work_r;
    fix_status_s = ST_OK;
    q_s          = par_r ^ work_r[0];
    if (!mode_r) begin
      for (int k = 0; k < PAR_W; k++) fix_word_s[32'sd1 << k] = syn_r[k];
      fix_word_s[0] = par_r ^ (^syn_r);
      fix_status_s  = ST_OK;
    end else if (q_s) begin
      // A single error lands on a real position; a syndrome past the word end cannot.
      if (32'(syn_r) < CODE_W) begin
        fix_word_s[syn_r] = ~work_r[syn_r];
        fix_status_s      = ST_CORR;
      end else begin
        fix_status_s = ST_UNCORR;
      end
    end else if (syn_r != '0) begin
      fix_status_s = ST_UNCORR;
    end else begin
      fix_status_s = ST_OK;
    end
  end

  // Work word, scan accumulators and the registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r         <= 1'b0;
      work_r         <= '0;
      idx_r          <= {{(PAR_W-1){1'b0}}, 1'b1};
      syn_r          <= '0;
      par_r          <= 1'b0;
      out_code_r     <= '0;
      out_data_r     <= '0;
      out_status_r   <= ST_OK;
      out_syndrome_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            mode_r <= bus.in_mode;
            work_r <= bus.in_mode ? bus.in_word : scat_code_s;
            idx_r  <= {{(PAR_W-1){1'b0}}, 1'b1};
            syn_r  <= '0;
            par_r  <= 1'b0;
          end else begin
            mode_r <= mode_r;
          end
        end
        S_SCAN: begin
          if (work_r[idx_r]) begin
            syn_r <= syn_r ^ idx_r;
            par_r <= ~par_r;
          end else begin
            par_r <= par_r;
          end
          idx_r <= idx_r + {{(PAR_W-1){1'b0}}, 1'b1};
        end
        S_FIX: begin
          work_r         <= fix_word_s;
          out_code_r     <= fix_word_s;
          out_data_r     <= gath_data_s;
          out_status_r   <= fix_status_s;
          out_syndrome_r <= syn_r;
        end
        default: begin
          work_r <= work_r;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_code     = out_code_r;
  assign bus.out_data     = out_data_r;
  assign bus.out_status   = out_status_r;
  assign bus.out_syndrome = out_syndrome_r;

`ifdef HAMMING_ERR_CNT_EN
  logic [15:0] corr_cnt_r;
  logic [15:0] uncorr_cnt_r;
  logic        fix_dec_s;

  assign fix_dec_s = (state_r == S_FIX) & mode_r;

  // Saturating decode event counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_r   <= 16'h0000;
      uncorr_cnt_r <= 16'h0000;
    end else if (cnt_clr) begin
      corr_cnt_r   <= 16'h0000;
      uncorr_cnt_r <= 16'h0000;
    end else begin
      if (fix_dec_s && (fix_status_s == ST_CORR) && (corr_cnt_r != 16'hFFFF))
        corr_cnt_r <= corr_cnt_r + 16'h0001;
      else
        corr_cnt_r <= corr_cnt_r;
      if (fix_dec_s && (fix_status_s == ST_UNCORR) && (uncorr_cnt_r != 16'hFFFF))
        uncorr_cnt_r <= uncorr_cnt_r + 16'h0001;
      else
        uncorr_cnt_r <= uncorr_cnt_r;
    end
  end

  assign corr_cnt   = corr_cnt_r;
  assign uncorr_cnt = uncorr_cnt_r;
`endif

endmodule

// File: tb/tb_hamming_secded_seq.sv
// Randomised self-checking bench for hamming_secded_seq against a behavioural
// Hamming model; a second DATA_W=8 instance covers the out-of-range syndrome.
`timescale 1ns/1ps
module tb_hamming_secded_seq;
  import hamming_pkg::*;

  localparam int DW  = 11;
  localparam int CW  = 16;
  localparam int PW  = 4;
  localparam int DW8 = 8;
  localparam int CW8 = 13;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_corr = 0;
  int   exp_uncorr = 0;

  always #5 clk = ~clk;

  hamming_secded_seq_if #(.DATA_W(DW))  ifc  ();
  hamming_secded_seq_if #(.DATA_W(DW8)) ifc8 ();

`ifdef HAMMING_ERR_CNT_EN
  logic        cnt_clr  = 1'b0;
  logic        cnt_clr8 = 1'b0;
  logic [15:0] corr_cnt, uncorr_cnt, corr_cnt8, uncorr_cnt8;
`endif

  hamming_secded_seq #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef HAMMING_ERR_CNT_EN
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt),
`endif
    .bus        (ifc.slave)
  );

  hamming_secded_seq #(.DATA_W(DW8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef HAMMING_ERR_CNT_EN
    .cnt_clr    (cnt_clr8),
    .corr_cnt   (corr_cnt8),
    .uncorr_cnt (uncorr_cnt8),
`endif
    .bus        (ifc8.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Textbook encode: data on non-power-of-two slots, p(2^k) covers positions with bit k set.
  function automatic logic [CW-1:0] m_encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int j;
    logic b;
    c = '0;
    j = 0;
    for (int p = 1; p < CW; p++)
      if ((p & (p - 1)) != 0) begin c[p] = d[j]; j++; end
    for (int k = 0; k < PW; k++) begin
      b = 1'b0;
      for (int p = 1; p < CW; p++) if (((p >> k) & 1) == 1) b ^= c[p];
      c[1 << k] = b;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [DW-1:0] m_data(input logic [CW-1:0] w);
    logic [DW-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int p = 1; p < CW; p++)
      if ((p & (p - 1)) != 0) begin d[j] = w[p]; j++; end
    return d;
  endfunction

  function automatic void m_decode(input logic [CW-1:0] w, output logic [CW-1:0] fixed,
                                   output logic [1:0] st, output logic [PW-1:0] syn);
    int s;
    logic all;
    s = 0;
    for (int p = 1; p < CW; p++) if (w[p]) s ^= p;
    all = ^w;
    syn = PW'(s);
    fixed = w;
    if (s == 0 && !all) st = 2'b00;
    else if (all) begin fixed[s] = ~fixed[s]; st = 2'b01; end
    else st = 2'b10;
  endfunction

  task automatic run_txn(input string tag, input logic mode, input logic [CW-1:0] word,
                         input int stall, input logic [CW-1:0] e_code, input logic [DW-1:0] e_data,
                         input logic [1:0] e_st, input logic [PW-1:0] e_syn);
    int n;
    @(negedge clk);
    n = 0;
    while (!ifc.in_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, ".in_ready"}, 32'(ifc.in_ready), 32'd1);
    ifc.in_valid  = 1'b1;
    ifc.in_mode   = mode;
    ifc.in_word   = word;
    ifc.out_ready = (stall == 0);
    @(posedge clk);
    // n counts rising edges with the accepting edge as the first one
    n = 1;
    @(negedge clk);
    ifc.in_valid = 1'($urandom_range(0, 1));
    ifc.in_mode  = ~mode;
    ifc.in_word  = CW'($urandom);
    while (!ifc.out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      ifc.in_valid = 1'($urandom_range(0, 1));
      ifc.in_word  = CW'($urandom);
    end
    ifc.in_valid = 1'b0;
    check({tag, ".latency"}, n, CW + 1);
    for (int c = 0; c <= stall; c++) begin
      check({tag, ".out_valid"}, 32'(ifc.out_valid), 32'd1);
      check({tag, ".in_ready_busy"}, 32'(ifc.in_ready), 32'd0);
      check({tag, ".code"}, 32'(ifc.out_code), 32'(e_code));
      check({tag, ".data"}, 32'(ifc.out_data), 32'(e_data));
      check({tag, ".status"}, 32'(ifc.out_status), 32'(e_st));
      check({tag, ".syndrome"}, 32'(ifc.out_syndrome), 32'(e_syn));
      if (c == stall) ifc.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, ".valid_drop"}, 32'(ifc.out_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(ifc.in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0]  d;
    logic [CW-1:0]  c, w, fixed;
    logic [1:0]     st;
    logic [PW-1:0]  syn;
    logic           mode;
    int             nerr, p1, p2, n, seen;

    ifc.in_valid  = 1'b0; ifc.in_mode  = 1'b0; ifc.in_word  = '0; ifc.out_ready  = 1'b0;
    ifc8.in_valid = 1'b0; ifc8.in_mode = 1'b0; ifc8.in_word = '0; ifc8.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", 32'(ifc.in_ready), 32'd1);
    check("rst.out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst.out_code", 32'(ifc.out_code), 32'd0);
    check("rst.out_data", 32'(ifc.out_data), 32'd0);
    check("rst.out_status", 32'(ifc.out_status), 32'd0);
    check("rst.out_syndrome", 32'(ifc.out_syndrome), 32'd0);
    rst_n = 1'b1;

    run_txn("enc_000", 1'b0, 16'h0000, 0, 16'h0000, 11'h000, 2'b00, 4'h0);
    run_txn("enc_7ff", 1'b0, 16'hF7FF, 0, 16'hFFFF, 11'h7FF, 2'b00, 4'hF);
    run_txn("dec_ffff", 1'b1, 16'hFFFF, 0, 16'hFFFF, 11'h7FF, 2'b00, 4'h0);
    run_txn("dec_bit5", 1'b1, 16'hFFDF, 5, 16'hFFFF, 11'h7FF, 2'b01, 4'h5);
    run_txn("dec_p0", 1'b1, 16'hFFFE, 0, 16'hFFFF, 11'h7FF, 2'b01, 4'h0);
    run_txn("dec_double", 1'b1, 16'hFFDE, 0, 16'hFFDE, 11'h7FD, 2'b10, 4'h5);
`ifdef HAMMING_ERR_CNT_EN
    check("cnt.corr_directed", 32'(corr_cnt), 32'd2);
    check("cnt.uncorr_directed", 32'(uncorr_cnt), 32'd1);
`endif
    exp_corr = 2;
    exp_uncorr = 1;

    for (int t = 0; t < 40; t++) begin
      d    = DW'($urandom);
      c    = m_encode(d);
      mode = 1'($urandom_range(0, 1));
      if (!mode) begin
        run_txn("rnd_enc", 1'b0, {5'($urandom), d}, $urandom_range(0, 3),
                c, d, 2'b00, {c[8], c[4], c[2], c[1]});
      end else begin
        nerr = $urandom_range(0, 2);
        p1   = $urandom_range(0, CW - 1);
        p2   = (p1 + $urandom_range(1, CW - 1)) % CW;
        w    = c;
        if (nerr >= 1) w[p1] = ~w[p1];
        if (nerr == 2) w[p2] = ~w[p2];
        m_decode(w, fixed, st, syn);
        if (st == 2'b01) exp_corr++;
        if (st == 2'b10) exp_uncorr++;
        run_txn("rnd_dec", 1'b1, w, $urandom_range(0, 3), fixed, m_data(fixed), st, syn);
      end
    end
`ifdef HAMMING_ERR_CNT_EN
    check("cnt.corr_random", 32'(corr_cnt), 32'(exp_corr));
    check("cnt.uncorr_random", 32'(uncorr_cnt), 32'(exp_uncorr));
`endif

    // Reset while the scan is at index 6: transaction must vanish.
    @(negedge clk);
    ifc.in_valid = 1'b1; ifc.in_mode = 1'b0; ifc.in_word = 16'h07FF; ifc.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.in_ready", 32'(ifc.in_ready), 32'd1);
    check("midrst.out_valid", 32'(ifc.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifc.out_valid) seen++;
    end
    check("midrst.no_result", seen, 0);
    check("midrst.idle", 32'(ifc.in_ready), 32'd1);
`ifdef HAMMING_ERR_CNT_EN
    check("cnt.corr_after_rst", 32'(corr_cnt), 32'd0);
    check("cnt.uncorr_after_rst", 32'(uncorr_cnt), 32'd0);
`endif
    d = DW'($urandom);
    c = m_encode(d);
    run_txn("post_rst", 1'b0, {5'd0, d}, 0, c, d, 2'b00, {c[8], c[4], c[2], c[1]});

`ifdef HAMMING_ERR_CNT_EN
    cnt_clr = 1'b1;
`endif
    w = c;
    w[3] = ~w[3];
    run_txn("clr_coincide", 1'b1, w, 0, c, d, 2'b01, 4'h3);
`ifdef HAMMING_ERR_CNT_EN
    cnt_clr = 1'b0;
    check("cnt.corr_clr_wins", 32'(corr_cnt), 32'd0);
    check("cnt.uncorr_clr_wins", 32'(uncorr_cnt), 32'd0);
`endif

    // DATA_W=8: syndrome 14 lies beyond the 13-bit codeword.
    @(negedge clk);
    ifc8.in_valid = 1'b1; ifc8.in_mode = 1'b1; ifc8.in_word = 13'h0114;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    ifc8.in_valid = 1'b0;
    while (!ifc8.out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("w8.latency", n, CW8 + 1);
    check("w8.status", 32'(ifc8.out_status), 32'd2);
    check("w8.syndrome", 32'(ifc8.out_syndrome), 32'd14);
    check("w8.code", 32'(ifc8.out_code), 32'h0114);
    check("w8.data", 32'(ifc8.out_data), 32'h00);
`ifdef HAMMING_ERR_CNT_EN
    check("w8.uncorr_cnt", 32'(uncorr_cnt8), 32'd1);
    check("w8.corr_cnt", 32'(corr_cnt8), 32'd0);
`endif
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_secded_seq.md
Name: hamming_secded_seq

Overview:
- Parametrised, multi-cycle Hamming SECDED encoder/decoder engine; next generation of the datapath's fixed 11-bit p0/p1/p2/p4/p8 parity and pack/unpack operations.
- Supports any data width, with selectable encode or decode mode per transaction.
- Sits beside the ALU as a valid/ready coprocessor: the core issues a word, stalls or polls, and reads back the codeword or the corrected data plus status.

Parameters:
- DATA_W, 11, payload width in bits (>=4).
- PAR_W, derived, smallest P with 2^P >= DATA_W+P+1; 4 at default.
- CODE_W, derived, DATA_W+PAR_W+1; 16 at default.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine idle, can accept.
- in_mode  in  1  0=encode, 1=decode; sampled on accept.
- in_word  in  CODE_W  decode: codeword; encode: data in [DATA_W-1:0], upper bits ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_code  out  CODE_W  encoded or corrected codeword.
- out_data  out  DATA_W  extracted (corrected) data.
- out_status  out  2  00 OK, 01 CORRECTED, 10 UNCORRECTABLE.
- out_syndrome  out  PAR_W  final Hamming syndrome (encode: parity bits written).

Behaviour:
- Codeword layout:
  - bit 0 = overall parity p0.
  - Bit positions 2^k (k<PAR_W) = parity p(2^k).
  - Remaining positions 3,5,6,7,9… hold data bits 0..DATA_W-1 in ascending order.
- FSM states: IDLE, SCAN, FIX, DONE.
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_code=0, out_data=0, out_status=00, out_syndrome=0, index=1, accumulators=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch mode and work word (encode: data scattered, parity positions and bit 0 zeroed); clear syndrome and parity accumulators; index=1; go to SCAN.
- SCAN, one position per cycle, index 1..CODE_W-1:
  - If work[index]=1: syndrome ^= index[PAR_W-1:0] and parity ^= 1.
  - After index CODE_W-1: go to FIX.
- FIX, one cycle, encode:
  - Write syndrome bit k into position 2^k.
  - p0 = parity ^ (^syndrome).
  - status=OK.
- FIX, one cycle, decode:
  - q = parity ^ work[0].
  - s==0 & q==0: OK.
  - q==1 & s<CODE_W: flip bit s (s==0 flips p0); CORRECTED.
  - q==1 & s>=CODE_W: UNCORRECTABLE.
  - s!=0 & q==0: UNCORRECTABLE.
  - UNCORRECTABLE: word left unmodified.
  - In all cases register outputs and go to DONE.
- DONE:
  - out_valid=1; all outputs held stable until out_valid&out_ready, then IDLE.
  - in_ready returns the following cycle; no same-cycle bypass.
- Latency: out_valid first high CODE_W+1 rising edges after the accepting edge (17 at default). Throughput: one transaction per CODE_W+2 cycles with out_ready tied high.
- in_valid while busy is ignored; no queueing.
- Reset mid-SCAN/FIX/DONE discards the transaction; no out_valid is produced for it.

Optional Feature:
- Macro: HAMMING_ERR_CNT_EN.
- With the macro defined, adds these ports:
  - cnt_clr in 1 (synchronous).
  - corr_cnt out 16.
  - uncorr_cnt out 16.
- Counters increment on the FIX cycle of a decode with the matching status. Both saturate at 16'hFFFF and reset to 0.
- cnt_clr coinciding with an increment: clear wins.
- Without the macro: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package hamming_pkg:
  - status typedef enum (ST_OK, ST_CORR, ST_UNCORR).
  - FSM state enum.
  - Constant function par_w_f(DATA_W).
  - Function is_pow2.
- One sub-module hamming_scatter_gather, purely combinational and parametrised on DATA_W:
  - Scatter: data to codeword positions, parity slots zero.
  - Gather: codeword to data.

Test Plan:
- Encode 11'h000 -> out_code 16'h0000, status 00, after exactly 17 cycles.
- Encode 11'h7FF -> out_code 16'hFFFF, syndrome 4'hF; decode 16'hFFFF -> data 11'h7FF, status 00.
- Decode 16'hFFDF (bit 5 flipped) -> status 01, syndrome 5, out_code 16'hFFFF, data 11'h7FF.
- Decode 16'hFFFE -> status 01, syndrome 0, out_code 16'hFFFF.
- Decode 16'hFFDE -> status 10, syndrome 5, out_code 16'hFFDE. With HAMMING_ERR_CNT_EN, counters corr_cnt=2, uncorr_cnt=1 after this sequence.
- Backpressure and reset:
  - out_ready low 5 cycles -> outputs stable, in_ready 0.
  - rst_n pulsed at SCAN index 6 -> IDLE, no out_valid.
  - DATA_W=8 decode 13'h0114 -> syndrome 14 >= 13 -> status 10.
